// File: rtl/pulse_stretch.sv
// Purpose : stretches a trigger event on `trig` into a HOLD_LEN-cycle high level on `out`,
//           then enforces a GAP_LEN-cycle lockout before the next trigger can be accepted.
// Latency : 1 cycle from the trigger event to out/busy high; done pulses on the cycle the hold ends.
// Backpressure: none; trigger events that arrive outside IDLE are dropped,
//           except during HOLD with RETRIG=1, where they restart the hold.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous reset, active low
//   trig - trigger pulse/level (rising edge when EDGE=1, high level when EDGE=0)
//   out  - registered stretched level
//   busy - registered, high whenever the block is not idle
//   done - registered single-cycle pulse on the cycle after the last hold cycle

module pulse_stretch #(
  parameter int CW       = 16,
  parameter int HOLD_LEN = 50000,
  parameter int GAP_LEN  = 1000,
  parameter bit RETRIG   = 1'b0,
  parameter bit EDGE     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // The counter holds "cycles remaining after this one", so a phase of
  // length L is loaded with L-1 and ends on the cycle where cnt is zero.
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_LEN - 1);
  localparam logic [CW-1:0] GAP_RELOAD  = CW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
  localparam bit            HAS_GAP     = (GAP_LEN > 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            out_q,   out_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            trig_d_q, trig_d_d;
  logic            trig_evt;
  logic            cnt_zero;

  // Trigger event: rising edge against the previous-cycle copy, or the raw level.
  // trig_d is cleared in reset, so a trig already high at release counts as an edge.
  always_comb begin
    trig_evt = trig;
    if (EDGE) begin
      trig_evt = trig & ~trig_d_q;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    trig_d_d = trig;

    case (state_q)
      ST_IDLE: begin
        if (trig_evt) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_RELOAD;
        end
      end

      ST_HOLD: begin
        // A retrigger wins even on the last hold cycle, so out never drops
        // and no done is produced for the interrupted hold.
        if (RETRIG && trig_evt) begin
          cnt_d = HOLD_RELOAD;
        end else if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done_d = 1'b1;
          if (HAS_GAP) begin
            state_d = ST_GAP;
            cnt_d   = GAP_RELOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end

      ST_GAP: begin
        // Triggers are deliberately ignored here, including on the final
        // gap cycle; only IDLE accepts a new trigger.
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    out_d  = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      trig_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      trig_d_q <= trig_d_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Purpose : self-checking bench for pulse_stretch across four parameter sets.
// Latency : each vector row is driven on the falling edge and checked 1 time unit after the next rising edge.
// Backpressure: not applicable.

module tb_pulse_stretch;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] trig_v;

  logic out_a, busy_a, done_a;
  logic out_b, busy_b, done_b;
  logic out_c, busy_c, done_c;
  logic out_d, busy_d, done_d;

  wire [3:0] out_v  = {out_d,  out_c,  out_b,  out_a};
  wire [3:0] busy_v = {busy_d, busy_c, busy_b, busy_a};
  wire [3:0] done_v = {done_d, done_c, done_b, done_a};

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a: basic edge mode with lockout
  pulse_stretch #(.CW(8), .HOLD_LEN(4), .GAP_LEN(2), .RETRIG(1'b0), .EDGE(1'b1)) u_a (
    .clk(clk), .rst(rst_v[0]), .trig(trig_v[0]), .out(out_a), .busy(busy_a), .done(done_a));
  // b: retrigger enabled
  pulse_stretch #(.CW(8), .HOLD_LEN(4), .GAP_LEN(2), .RETRIG(1'b1), .EDGE(1'b1)) u_b (
    .clk(clk), .rst(rst_v[1]), .trig(trig_v[1]), .out(out_b), .busy(busy_b), .done(done_b));
  // c: level mode, no gap
  pulse_stretch #(.CW(8), .HOLD_LEN(4), .GAP_LEN(0), .RETRIG(1'b0), .EDGE(1'b0)) u_c (
    .clk(clk), .rst(rst_v[2]), .trig(trig_v[2]), .out(out_c), .busy(busy_c), .done(done_c));
  // d: minimum hold, no gap
  pulse_stretch #(.CW(8), .HOLD_LEN(1), .GAP_LEN(0), .RETRIG(1'b0), .EDGE(1'b1)) u_d (
    .clk(clk), .rst(rst_v[3]), .trig(trig_v[3]), .out(out_d), .busy(busy_d), .done(done_d));

  typedef struct {
    int         dut;
    logic       rst;
    logic       trig;
    logic [2:0] exp;   // {out, busy, done} after the edge
  } vec_t;

  vec_t vecs[160];
  int   nvec;

  task automatic add(input int d, input logic r, input logic t, input logic [2:0] e);
    vecs[nvec].dut  = d;
    vecs[nvec].rst  = r;
    vecs[nvec].trig = t;
    vecs[nvec].exp  = e;
    nvec++;
  endtask

  task automatic addn(input int d, input logic r, input logic t, input logic [2:0] e, input int n);
    for (int k = 0; k < n; k++) add(d, r, t, e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_out, n_busy, n_done;
    checks = 0;
    errors = 0;
    nvec   = 0;
    rst_v  = 4'b0000;
    trig_v = 4'b0000;

    // ---------------- DUT a: HOLD_LEN=4 GAP_LEN=2 edge mode ----------------
    addn(0, 0, 0, 3'b000, 2);      // reset state
    add (0, 0, 1, 3'b000);         // trigger under reset ignored
    add (0, 1, 1, 3'b110);         // trig high at release fires (trig_d cleared)
    add (0, 1, 1, 3'b110);         // held high: no new edge
    add (0, 1, 0, 3'b110);
    add (0, 1, 0, 3'b110);
    add (0, 1, 0, 3'b011);         // hold end: done, gap
    add (0, 1, 0, 3'b010);
    addn(0, 1, 0, 3'b000, 2);
    // single pulse and lockout
    add (0, 1, 1, 3'b110);         // "edge 10"
    addn(0, 1, 0, 3'b110, 3);      // 11..13
    add (0, 1, 0, 3'b011);         // 14: done
    add (0, 1, 1, 3'b010);         // 15: pulse in gap dropped
    add (0, 1, 0, 3'b000);         // 16: idle
    add (0, 1, 1, 3'b110);         // 17: accepted
    add (0, 1, 0, 3'b110);
    add (0, 1, 1, 3'b110);         // pulse in hold ignored (RETRIG=0)
    add (0, 1, 0, 3'b110);
    add (0, 1, 0, 3'b011);
    add (0, 1, 0, 3'b010);         // gap last cycle reached
    add (0, 1, 1, 3'b000);         // edge on last gap cycle dropped
    add (0, 1, 1, 3'b000);         // still high: no edge
    add (0, 1, 0, 3'b000);
    // reset mid-hold
    add (0, 1, 1, 3'b110);
    add (0, 1, 0, 3'b110);
    addn(0, 0, 0, 3'b000, 2);      // abort, no done
    add (0, 1, 0, 3'b000);
    add (0, 1, 1, 3'b110);
    addn(0, 1, 0, 3'b110, 3);
    add (0, 1, 0, 3'b011);
    add (0, 1, 0, 3'b010);
    add (0, 1, 0, 3'b000);

    // ---------------- DUT b: RETRIG=1 ----------------
    addn(1, 0, 0, 3'b000, 2);
    add (1, 1, 0, 3'b000);
    add (1, 1, 1, 3'b110);         // "edge 10"
    add (1, 1, 0, 3'b110);
    add (1, 1, 1, 3'b110);         // "edge 12" reload
    addn(1, 1, 0, 3'b110, 3);      // 13..15
    add (1, 1, 0, 3'b011);         // 16: done
    add (1, 1, 0, 3'b010);
    add (1, 1, 0, 3'b000);
    // retrigger on the last hold cycle
    add (1, 1, 1, 3'b110);
    addn(1, 1, 0, 3'b110, 3);
    add (1, 1, 1, 3'b110);         // would have been the done edge: reload instead
    addn(1, 1, 0, 3'b110, 3);
    add (1, 1, 0, 3'b011);
    add (1, 1, 0, 3'b010);
    add (1, 1, 0, 3'b000);

    // ---------------- DUT c: level mode, GAP_LEN=0 ----------------
    addn(2, 0, 1, 3'b000, 2);      // level under reset ignored
    addn(2, 1, 1, 3'b110, 4);
    add (2, 1, 1, 3'b001);
    addn(2, 1, 1, 3'b110, 4);
    add (2, 1, 1, 3'b001);
    add (2, 1, 0, 3'b000);

    // ---------------- DUT d: HOLD_LEN=1, GAP_LEN=0 ----------------
    addn(3, 0, 0, 3'b000, 2);
    add (3, 1, 0, 3'b000);
    for (int k = 0; k < 3; k++) begin
      add(3, 1, 1, 3'b110);
      add(3, 1, 0, 3'b001);
    end
    add (3, 1, 0, 3'b000);
    add (3, 1, 1, 3'b110);
    add (3, 1, 1, 3'b001);         // still high: no second edge
    add (3, 1, 1, 3'b000);
    add (3, 1, 0, 3'b000);

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      rst_v[vecs[i].dut]  = vecs[i].rst;
      trig_v[vecs[i].dut] = vecs[i].trig;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d dut%0d out",  i, vecs[i].dut), 32'(out_v[vecs[i].dut]),  32'(vecs[i].exp[2]));
      check($sformatf("vec%0d dut%0d busy", i, vecs[i].dut), 32'(busy_v[vecs[i].dut]), 32'(vecs[i].exp[1]));
      check($sformatf("vec%0d dut%0d done", i, vecs[i].dut), 32'(done_v[vecs[i].dut]), 32'(vecs[i].exp[0]));
    end

    // Hand sequence: one pulse on a, count cycles of out/busy/done over a bounded window.
    n_out = 0; n_busy = 0; n_done = 0;
    @(negedge clk);
    trig_v[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      n_out  += int'(out_a);
      n_busy += int'(busy_a);
      n_done += int'(done_a);
      @(negedge clk);
      trig_v[0] = 1'b0;
    end
    check("seq_a out_cycles",  n_out,  4);
    check("seq_a busy_cycles", n_busy, 6);
    check("seq_a done_pulses", n_done, 1);

    // Hand sequence: level mode held for 15 edges -> three full periods of 5.
    n_out = 0; n_done = 0;
    @(negedge clk);
    trig_v[2] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      n_out  += int'(out_c);
      n_done += int'(done_c);
    end
    check("seq_c out_cycles",  n_out,  12);
    check("seq_c done_pulses", n_done, 3);
    @(negedge clk);
    trig_v[2] = 1'b0;
    @(posedge clk);
    #1;
    check("seq_c idle_busy", 32'(busy_c), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
